edge_req_arbiter: RTL and testbench

Round-robin scheduler that shares one single-transaction resource among N requesters whose requests are signalled by rising edges. Each request line is edge-detected and the event is held in a pending bit. The arbiter grants one pending requester at a time with a start/done handshake and rotates priority after each completed or aborted grant. It sits between the edge-detector request sources and the shared datapath unit.

---
 rtl/edge_arb_pkg.sv | 47 ++++
 rtl/edge_req_arbiter_if.sv | 28 ++
 rtl/req_edge_det.sv | 42 ++++
 rtl/edge_req_arbiter.sv | 142 ++++++++++++++
 tb/tb_edge_req_arbiter.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/edge_arb_pkg.sv
// edge_arb_pkg: shared types and helpers for the edge-triggered round-robin arbiter.
//   arb_state_e : FSM state encoding (IDLE, BUSY)
//   CNT_W       : width of the BUSY-cycle abort counter (EDGE_ARB_TIMEOUT_EN builds)
//   MAX_N       : largest supported requester count
//   rr_pick     : round-robin pick of the first pending index at or after a pointer
package edge_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int CNT_W = 8;
  localparam int MAX_N = 16;

  // Search order is ptr, ptr+1, ..., wrapping at n. Returns 0 when nothing is
  // pending, so callers must qualify the result with |pend.
  function automatic logic [3:0] rr_pick(input logic [MAX_N-1:0] pend,
                                         input logic [3:0]       ptr,
                                         input int unsigned      n);
    logic [4:0] idx;
    logic       found;
    logic [3:0] pick;
    pick  = 4'd0;
    found = 1'b0;
    for (int off = 0; off < MAX_N; off++) begin
      if (off < int'(n)) begin
        idx = {1'b0, ptr} + 5'(off);
        if (idx >= 5'(n)) begin
          idx = idx - 5'(n);
        end else begin
          idx = idx;
        end
        if (!found && pend[idx[3:0]]) begin
          pick  = idx[3:0];
          found = 1'b1;
        end else begin
          pick = pick;
        end
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/edge_req_arbiter_if.sv
// edge_req_arbiter_if: request/grant/handshake bundle of the arbiter.
//   req, done            : driven by requesters / shared resource (master side)
//   gnt, gnt_id, start,
//   busy, lost, timeout  : driven by the arbiter (slave side)
interface edge_req_arbiter_if #(
  parameter int N = 4
);
  localparam int GW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  req;
  logic          done;
  logic [N-1:0]  gnt;
  logic [GW-1:0] gnt_id;
  logic          start;
  logic          busy;
  logic [N-1:0]  lost;
  logic          timeout;

  modport master (
    output req, done,
    input  gnt, gnt_id, start, busy, lost, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_id, start, busy, lost, timeout
  );
endinterface

// File: rtl/req_edge_det.sv
// req_edge_det: per-line rising-edge detector with a one-deep pending flag.
//   clk, rstn : clock, async active-low reset
//   req       : level request line
//   clr       : line is being granted this cycle
//   pend      : request event awaiting a grant
//   lost      : registered pulse, an event arrived while pend was already held
module req_edge_det (
  input  logic clk,
  input  logic rstn,
  input  logic req,
  input  logic clr,
  output logic pend,
  output logic lost
);

  logic req_q_r;
  logic pend_r;
  logic lost_r;
  logic rise_s;

  // req_q_r resets to 0, so a line already high at reset release counts as a rise.
  always_comb begin
    rise_s = req & ~req_q_r;
  end

  // Edge history, pending flag (a new rise beats a same-cycle clear) and overflow pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_q_r <= 1'b0;
      pend_r  <= 1'b0;
      lost_r  <= 1'b0;
    end else begin
      req_q_r <= req;
      pend_r  <= rise_s | (pend_r & ~clr);
      lost_r  <= rise_s & pend_r & ~clr;
    end
  end

  assign pend = pend_r;
  assign lost = lost_r;

endmodule

// File: rtl/edge_req_arbiter.sv
// edge_req_arbiter: round-robin scheduler for one single-transaction resource
// shared by N edge-signalled requesters.
//   clk, rstn : clock, async active-low reset
//   bus       : edge_req_arbiter_if.slave (req, done in; gnt, gnt_id, start,
//               busy, lost, timeout out)
// Optional build macro EDGE_ARB_TIMEOUT_EN: aborts a grant after TIMEOUT BUSY
// cycles without done; otherwise BUSY waits indefinitely and timeout stays 0.
module edge_req_arbiter
  import edge_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int TIMEOUT = 15
) (
  input logic             clk,
  input logic             rstn,
  edge_req_arbiter_if.slave bus
);

  localparam int GW = (N > 1) ? $clog2(N) : 1;

  arb_state_e    state_r;
  logic [N-1:0]  pend_s;
  logic [N-1:0]  clr_s;
  logic [N-1:0]  lost_s;
  logic [N-1:0]  gnt_r;
  logic [GW-1:0] gnt_id_r;
  logic [GW-1:0] ptr_r;
  logic [GW-1:0] next_ptr_s;
  logic          start_r;
  logic          busy_r;
  logic          timeout_r;
  logic [3:0]    pick_s;
  logic          grant_s;
  logic          to_hit_s;

  for (genvar i = 0; i < N; i++) begin : g_line
    req_edge_det u_det (
      .clk  (clk),
      .rstn (rstn),
      .req  (bus.req[i]),
      .clr  (clr_s[i]),
      .pend (pend_s[i]),
      .lost (lost_s[i])
    );
  end

  // Winner selection and the per-line clear that consumes its pending flag.
  always_comb begin
    pick_s  = rr_pick(MAX_N'(pend_s), 4'(ptr_r), N);
    grant_s = (state_r == IDLE) && (|pend_s);
    for (int i = 0; i < N; i++) begin
      clr_s[i] = grant_s && (pick_s == 4'(i));
    end
    if (gnt_id_r == GW'(N - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = gnt_id_r + GW'(1);
    end
  end

`ifdef EDGE_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_r;

  // Abort fires on the BUSY edge where the count would reach TIMEOUT.
  always_comb begin
    to_hit_s = (cnt_r == CNT_W'(TIMEOUT - 1));
  end

  // BUSY-cycle counter: cleared on entry to BUSY, counts cycles without done.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r <= '0;
    end else if (grant_s) begin
      cnt_r <= '0;
    end else if ((state_r == BUSY) && !bus.done) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end
`else
  // No abort path: BUSY lasts until done.
  always_comb begin
    to_hit_s = 1'b0;
  end
`endif

  // Arbiter FSM with registered grant outputs; done wins over a coincident abort.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= IDLE;
      ptr_r     <= '0;
      gnt_r     <= '0;
      gnt_id_r  <= '0;
      start_r   <= 1'b0;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      start_r   <= 1'b0;
      timeout_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            state_r  <= BUSY;
            gnt_r    <= N'(1) << pick_s;
            gnt_id_r <= pick_s[GW-1:0];
            start_r  <= 1'b1;
            busy_r   <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (bus.done || to_hit_s) begin
            state_r   <= IDLE;
            gnt_r     <= '0;
            gnt_id_r  <= '0;
            busy_r    <= 1'b0;
            ptr_r     <= next_ptr_s;
            timeout_r <= ~bus.done;
          end else begin
            state_r <= BUSY;
          end
        end
        default: begin
          state_r  <= IDLE;
          gnt_r    <= '0;
          gnt_id_r <= '0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_r;
  assign bus.gnt_id  = gnt_id_r;
  assign bus.start   = start_r;
  assign bus.busy    = busy_r;
  assign bus.lost    = lost_s;
  assign bus.timeout = timeout_r;

endmodule

// File: tb/tb_edge_req_arbiter.sv
// tb_edge_req_arbiter: self-checking bench for edge_req_arbiter (N=4).
// Directed vector table, hand-written corner sequences and a randomized run
// checked against a behavioural model of the arbitration rules.
module tb_edge_req_arbiter;

  localparam int N  = 4;
  localparam int TO = 15;

  logic clk;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  edge_req_arbiter_if #(.N(N)) bus ();

  edge_req_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  logic [N-1:0] m_prev, m_pend, m_lost;
  int           m_ptr, m_id, m_bc;
  bit           m_busy, m_start, m_to;

  task automatic model_reset();
    m_prev = '0; m_pend = '0; m_lost = '0;
    m_ptr = 0; m_id = 0; m_bc = 0;
    m_busy = 0; m_start = 0; m_to = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic d);
    logic [N-1:0] rise;
    int pick;
    bit g;
    rise   = r & ~m_prev;
    m_prev = r;
    g      = !m_busy && (m_pend != '0);
    pick   = -1;
    if (g) begin
      for (int k = 0; k < N; k++) begin
        if (pick < 0 && m_pend[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
      end
    end
    for (int i = 0; i < N; i++) begin
      m_lost[i] = rise[i] && m_pend[i] && !(g && pick == i);
      m_pend[i] = rise[i] || (m_pend[i] && !(g && pick == i));
    end
    m_to = 0;
    if (m_busy) begin
      m_start = 0;
      if (d) begin
        m_busy = 0;
        m_ptr  = (m_id + 1) % N;
      end else begin
        m_bc = m_bc + 1;
`ifdef EDGE_ARB_TIMEOUT_EN
        if (m_bc == TO) begin
          m_busy = 0;
          m_ptr  = (m_id + 1) % N;
          m_to   = 1;
        end
`endif
      end
    end else begin
      m_start = g;
      if (g) begin
        m_busy = 1;
        m_id   = pick;
        m_bc   = 0;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model(input string tag);
    logic [N-1:0] eg;
    eg = m_busy ? (N'(1) << m_id) : '0;
    chk({tag, ".gnt"}, 32'(bus.gnt), 32'(eg));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(m_busy));
    chk({tag, ".start"}, 32'(bus.start), 32'(m_start));
    chk({tag, ".lost"}, 32'(bus.lost), 32'(m_lost));
    chk({tag, ".timeout"}, 32'(bus.timeout), 32'(m_to));
    if (m_busy) chk({tag, ".gnt_id"}, 32'(bus.gnt_id), 32'(m_id));
  endtask

  task automatic step(input logic [N-1:0] r, input logic d, input string tag);
    bus.req  = r;
    bus.done = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
    compare_model(tag);
  endtask

  task automatic do_reset(input logic [N-1:0] r_hold);
    @(negedge clk);
    rstn     = 1'b0;
    bus.req  = r_hold;
    bus.done = 1'b0;
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] gnt;
    logic [1:0]   id;
    logic         busy;
    logic         start;
    logic [N-1:0] lost;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [N-1:0] rr;
    logic         dd;
    int           order[N];
    int           waited;
    int           nb;

    tbl[0]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000};
    tbl[1]  = '{4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000};
    tbl[2]  = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1, 4'b0000};
    tbl[3]  = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 4'b0000};
    tbl[4]  = '{4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000};
    tbl[5]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000};
    tbl[6]  = '{4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000};
    tbl[7]  = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1, 4'b0000};
    tbl[8]  = '{4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 4'b0000};
    tbl[9]  = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 4'b0000};
    tbl[10] = '{4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 4'b0010};
    tbl[11] = '{4'b0011, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000};
    tbl[12] = '{4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1, 4'b0000};
    tbl[13] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000};
    tbl[14] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000};

    rstn     = 1'b0;
    bus.req  = '0;
    bus.done = 1'b0;
    model_reset();
    #12;
    chk("reset.gnt", 32'(bus.gnt), 32'd0);
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.start", 32'(bus.start), 32'd0);
    chk("reset.lost", 32'(bus.lost), 32'd0);
    chk("reset.timeout", 32'(bus.timeout), 32'd0);
    chk("reset.gnt_id", 32'(bus.gnt_id), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // single request, wrap from ptr=3, overflow of line 1
    for (int v = 0; v < 15; v++) begin
      bus.req  = tbl[v].req;
      bus.done = tbl[v].done;
      @(posedge clk);
      model_edge(tbl[v].req, tbl[v].done);
      #1;
      chk($sformatf("vec%0d.gnt", v), 32'(bus.gnt), 32'(tbl[v].gnt));
      chk($sformatf("vec%0d.busy", v), 32'(bus.busy), 32'(tbl[v].busy));
      chk($sformatf("vec%0d.start", v), 32'(bus.start), 32'(tbl[v].start));
      chk($sformatf("vec%0d.lost", v), 32'(bus.lost), 32'(tbl[v].lost));
      if (tbl[v].busy) chk($sformatf("vec%0d.gnt_id", v), 32'(bus.gnt_id), 32'(tbl[v].id));
    end

    // fairness: all lines rise together, done two cycles after each start
    do_reset('0);
    step(4'b0000, 1'b0, "fair");
    step(4'b1111, 1'b0, "fair");
    for (int k = 0; k < N; k++) begin
      waited = 0;
      while (!bus.start && waited < 20) begin
        step(4'b1111, 1'b0, "fair");
        waited++;
      end
      chk("fair.start_seen", 32'(bus.start), 32'd1);
      if (k > 0) chk("fair.idle_gap", 32'(waited), 32'd1);
      order[k] = int'(bus.gnt_id);
      step(4'b1111, 1'b0, "fair");
      step(4'b1111, 1'b1, "fair");
      chk("fair.busy_after_done", 32'(bus.busy), 32'd0);
    end
    for (int k = 0; k < N; k++) chk($sformatf("fair.order%0d", k), 32'(order[k]), 32'(k));

    // coincident set/clear on line 0, done in the start cycle
    do_reset('0);
    step(4'b1000, 1'b0, "coin");
    step(4'b1000, 1'b0, "coin");
    chk("coin.first_id", 32'(bus.gnt_id), 32'd3);
    step(4'b1001, 1'b0, "coin");
    step(4'b1100, 1'b0, "coin");
    step(4'b1100, 1'b1, "coin");
    step(4'b1101, 1'b0, "coin");
    chk("coin.grant0", 32'(bus.gnt), 32'b0001);
    step(4'b1101, 1'b1, "coin");
    chk("coin.done_in_start", 32'(bus.busy), 32'd0);
    step(4'b1101, 1'b0, "coin");
    chk("coin.then2", 32'(bus.gnt_id), 32'd2);
    step(4'b1101, 1'b1, "coin");
    step(4'b1101, 1'b0, "coin");
    chk("coin.regrant0", 32'(bus.gnt), 32'b0001);
    step(4'b1101, 1'b1, "coin");

    // asynchronous reset in the middle of a transaction, req held high across it
    do_reset('0);
    step(4'b0010, 1'b0, "rst");
    step(4'b0010, 1'b0, "rst");
    chk("rst.busy_before", 32'(bus.busy), 32'd1);
    #3;
    rstn = 1'b0;
    #1;
    chk("rst.gnt", 32'(bus.gnt), 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.start", 32'(bus.start), 32'd0);
    chk("rst.gnt_id", 32'(bus.gnt_id), 32'd0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    step(4'b0010, 1'b0, "rst");
    chk("rst.no_start_on_release", 32'(bus.start), 32'd0);
    step(4'b0010, 1'b0, "rst");
    chk("rst.high_at_release_is_rise", 32'(bus.gnt), 32'b0010);
    step(4'b0010, 1'b1, "rst");

`ifdef EDGE_ARB_TIMEOUT_EN
    // abort after TO BUSY cycles, then next pending line is granted
    do_reset('0);
    step(4'b0011, 1'b0, "to");
    step(4'b0011, 1'b0, "to");
    nb = 1;
    for (int c = 0; c < 30; c++) begin
      step(4'b0011, 1'b0, "to");
      if (bus.timeout) break;
      nb++;
    end
    chk("to.pulse", 32'(bus.timeout), 32'd1);
    chk("to.busy_cycles", 32'(nb), 32'(TO));
    step(4'b0011, 1'b0, "to");
    chk("to.next_grant", 32'(bus.gnt), 32'b0010);
    step(4'b0011, 1'b1, "to");
`else
    nb = 0;
`endif

    // randomized traffic against the model
    do_reset('0);
    rr = '0;
    for (int c = 0; c < 600; c++) begin
      rr = rr ^ (N'($urandom) & N'($urandom));
      dd = ($urandom_range(0, 3) == 0);
      step(rr, dd, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
